// File: rtl/mdu_pkg.sv
// Shared multiply/divide unit definitions: op encodings, default latencies, op-class helpers.
package mdu_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned MDU_OP_W     = 4;
  localparam int unsigned MDU_MULT_LAT = 5;
  localparam int unsigned MDU_DIV_LAT  = 10;

  typedef enum logic [MDU_OP_W-1:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  // HI/LO register pair, also used for the pending result.
  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } hilo_t;

  // Ops that launch a multi-cycle operation.
  function automatic logic is_mdu_start(input logic [MDU_OP_W-1:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  // Ops that read HI/LO onto the E-stage result path.
  function automatic logic is_mdu_read(input logic [MDU_OP_W-1:0] op);
    return (op == MDU_MFHI) || (op == MDU_MFLO);
  endfunction

  // Ops that take the divide latency.
  function automatic logic is_mdu_div(input logic [MDU_OP_W-1:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit: result computed at start, held pending, committed to HI/LO
// after the fixed MIPS latency by a down-counter FSM.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_LAT = MDU_MULT_LAT,
  parameter int unsigned DIV_LAT  = MDU_DIV_LAT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [MDU_OP_W-1:0] mdu_op,
  input  logic [XLEN-1:0]     rs_e,
  input  logic [XLEN-1:0]     rt_e,
  input  logic                cancel,
  output logic                start,
  output logic                busy,
  output logic [XLEN-1:0]     mdu_rd
);

  localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
  localparam int unsigned PROD_W  = 2 * XLEN;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  hilo_t            hilo_q, hilo_d;
  hilo_t            pend_q, pend_d;
  logic             wr_pend_q, wr_pend_d;

  logic                     div_zero;
  logic                     div_ovf;
  logic [XLEN-1:0]          divisor;
  logic signed [PROD_W-1:0] prod_s;
  logic [PROD_W-1:0]        prod_u;
  hilo_t                    res;

  // Combinational result of the E-stage op from the forwarded operands.
  always_comb begin
    div_zero = (rt_e == '0);
    // Most-negative / -1 overflows; pin it to the wrapped quotient with zero remainder.
    div_ovf  = (rs_e == {1'b1, {(XLEN-1){1'b0}}}) && (rt_e == '1);
    divisor  = div_zero ? XLEN'(1) : rt_e;
    prod_s   = PROD_W'($signed(rs_e)) * PROD_W'($signed(rt_e));
    prod_u   = PROD_W'(rs_e) * PROD_W'(rt_e);
    res      = '0;
    case (mdu_op)
      MDU_MULT:  res = hilo_t'(prod_s);
      MDU_MULTU: res = hilo_t'(prod_u);
      MDU_DIV: begin
        if (div_ovf) begin
          res.lo = rs_e;
          res.hi = '0;
        end else begin
          res.lo = XLEN'($signed(rs_e) / $signed(divisor));
          res.hi = XLEN'($signed(rs_e) % $signed(divisor));
        end
      end
      MDU_DIVU: begin
        res.lo = rs_e / divisor;
        res.hi = rs_e % divisor;
      end
      default: res = '0;
    endcase
  end

  // Handshake and read-port outputs.
  always_comb begin
    busy   = (state_q == ST_RUN);
    start  = is_mdu_start(mdu_op) && !busy && !cancel;
    mdu_rd = '0;
    if (mdu_op == MDU_MFHI) begin
      mdu_rd = hilo_q.hi;
    end else if (mdu_op == MDU_MFLO) begin
      mdu_rd = hilo_q.lo;
    end
  end

  // Next-state: launch, count down, commit, and MTHI/MTLO writes while idle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hilo_d    = hilo_q;
    pend_d    = pend_q;
    wr_pend_d = wr_pend_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pend_d    = res;
          wr_pend_d = !(is_mdu_div(mdu_op) && div_zero);
          cnt_d     = is_mdu_div(mdu_op) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
          state_d   = ST_RUN;
        end else if (!cancel && (mdu_op == MDU_MTHI)) begin
          hilo_d.hi = rs_e;
        end else if (!cancel && (mdu_op == MDU_MTLO)) begin
          hilo_d.lo = rs_e;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          if (wr_pend_q) begin
            hilo_d = pend_q;
          end
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset that also aborts an op in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hilo_q    <= '0;
      pend_q    <= '0;
      wr_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hilo_q    <= hilo_d;
      pend_q    <= pend_d;
      wr_pend_q <= wr_pend_d;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus queues expectations, a negedge monitor checks them.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  mdu_op;
  logic [31:0] rs_e;
  logic [31:0] rt_e;
  logic        cancel;
  logic        start;
  logic        busy;
  logic [31:0] mdu_rd;

  mult_div_unit dut (
    .clk    (clk),
    .reset  (reset),
    .mdu_op (mdu_op),
    .rs_e   (rs_e),
    .rt_e   (rt_e),
    .cancel (cancel),
    .start  (start),
    .busy   (busy),
    .mdu_rd (mdu_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t q_read[$];
  logic q_start[$];
  int   q_fall[$];

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;
  int bcnt  = 0;

  function automatic void check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endfunction

  function automatic void exp_rd(input string name, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.val  = v;
    q_read.push_back(e);
  endfunction

  // Monitor: busy pulse length on each falling edge of busy, start on launch ops, mdu_rd on reads.
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy) begin
        bcnt++;
      end else if (bcnt != 0) begin
        if (q_fall.size() == 0) begin
          total++;
          bad++;
          $display("FAIL busy_len: unexpected busy pulse of %0d cycles", bcnt);
        end else begin
          check32("busy_len", 32'(bcnt), 32'(q_fall.pop_front()));
        end
        bcnt = 0;
      end
      assert (!(busy && (mdu_op != 4'd0))) else begin
        bad++;
        $display("FAIL op_while_busy: op=%0d issued with busy=1", mdu_op);
      end
      if ((mdu_op >= 4'd1) && (mdu_op <= 4'd4)) begin
        if (q_start.size() == 0) begin
          total++;
          bad++;
          $display("FAIL start: unexpected launch op %0d, start=%0b", mdu_op, start);
        end else begin
          check32("start", 32'(start), 32'(q_start.pop_front()));
        end
      end
      if ((mdu_op == 4'd5) || (mdu_op == 4'd6)) begin
        if (q_read.size() == 0) begin
          total++;
          bad++;
          $display("FAIL read: unexpected read op %0d, mdu_rd=0x%08h", mdu_op, mdu_rd);
        end else begin
          exp_t e;
          e = q_read.pop_front();
          check32(e.name, mdu_rd, e.val);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input logic c);
    mdu_op = o;
    rs_e   = a;
    rt_e   = b;
    cancel = c;
  endtask

  task automatic op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input logic c);
    drive(o, a, b, c);
    tick();
    drive(4'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && (n < 40)) begin
      tick();
      n++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles, want 0", n);
    end
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
    exp_rd({tag, "_hi"}, hi);
    exp_rd({tag, "_lo"}, lo);
    op(4'd5, 32'd0, 32'd0, 1'b0);
    op(4'd6, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input int lat);
    q_start.push_back(1'b1);
    q_fall.push_back(lat);
    op(o, a, b, 1'b0);
    wait_idle();
  endtask

  initial begin
    drive(4'd0, 32'd0, 32'd0, 1'b0);
    reset = 1'b0;
    repeat (3) tick();
    reset  = 1'b1;
    mon_en = 1'b1;

    read_hilo("reset", 32'h0000_0000, 32'h0000_0000);

    run_op(4'd1, 32'hFFFF_FFFE, 32'd3, 5);
    read_hilo("mult_m2x3", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    run_op(4'd2, 32'hFFFF_FFFF, 32'd2, 5);
    read_hilo("multu", 32'h0000_0001, 32'hFFFF_FFFE);

    run_op(4'd1, 32'h8000_0000, 32'd2, 5);
    read_hilo("mult_minx2", 32'hFFFF_FFFF, 32'h0000_0000);

    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 10);
    read_hilo("div_m7d2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    run_op(4'd3, 32'd7, 32'hFFFF_FFFE, 10);
    read_hilo("div_7dm2", 32'h0000_0001, 32'hFFFF_FFFD);

    op(4'd7, 32'h11, 32'd0, 1'b0);
    op(4'd8, 32'h22, 32'd0, 1'b0);
    read_hilo("mtxx", 32'h0000_0011, 32'h0000_0022);
    run_op(4'd4, 32'd5, 32'd0, 10);
    read_hilo("divu_by0", 32'h0000_0011, 32'h0000_0022);

    q_start.push_back(1'b0);
    op(4'd1, 32'd5, 32'd7, 1'b1);
    tick();
    op(4'd8, 32'd5, 32'd0, 1'b1);
    read_hilo("cancel", 32'h0000_0011, 32'h0000_0022);

    run_op(4'd1, 32'd3, 32'd4, 5);
    run_op(4'd4, 32'd100, 32'd7, 10);
    read_hilo("b2b_divu", 32'h0000_0002, 32'h0000_000E);

    q_start.push_back(1'b1);
    q_fall.push_back(3);
    op(4'd3, 32'd100, 32'd3, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    repeat (12) tick();
    read_hilo("rst_abort", 32'h0000_0000, 32'h0000_0000);

    repeat (2) tick();
    check32("queues_empty", 32'(q_read.size() + q_start.size() + q_fall.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
